blake_round_ctrl: RTL and testbench

- Sequencer and state-register owner for the BLAKE-512 compression rounds.
- On start, loads the 16-word working state v and walks counter_idx through NUM_ROUNDS×8 G-steps.
- For each step it selects the four G operands (a,b,c,d) from v and drives them to the G core. After the G latency, it captures the merged state returned by blake_state_update into v.
- Sits between the message/init loader (upstream) and the finalization block (downstream). v_out feeds blake_state_update, and v_state_next feeds back in.

---
 rtl/blake_round_ctrl.sv | 164 ++++++++++++++++
 tb/tb_blake_round_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 round sequencer: owns the 16-word working state v, walks the
// G-step index through NUM_ROUNDS*8 steps, presents the four G operands for
// each step and captures the merged state after the G latency.
// Optional build macro: BLAKE_ROUND_STALL_EN adds a stall input that freezes
// the sequencer while a step is in flight.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; v_out holds the last result
// S_ISSUE | operands valid, g_start pulses (captures here when G_LAT=0)
// S_WAIT  | counting down the G latency, captures when the count is 0
// S_DONE  | one-cycle done pulse, v_out holds the final state
module blake_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int G_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef BLAKE_ROUND_STALL_EN
  input  logic          stall,
`endif
  input  logic [1023:0] v_init,
  input  logic [1023:0] v_state_next,
  output logic [1023:0] v_out,
  output logic [6:0]    counter_idx,
  output logic [63:0]   a_in,
  output logic [63:0]   b_in,
  output logic [63:0]   c_in,
  output logic [63:0]   d_in,
  output logic          g_start,
  output logic          busy,
  output logic          done
);

  localparam int         TOTAL_STEPS = NUM_ROUNDS * 8;
  localparam logic [6:0] LAST_IDX    = 7'(TOTAL_STEPS - 1);
  localparam logic [2:0] WAIT_INIT   = 3'((G_LAT > 0) ? G_LAT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [1023:0]  v_next;
  logic [6:0]     idx_next;
  logic [2:0]     wait_cnt;
  logic [2:0]     wait_next;
  logic           capture;
  logic           hold_step;

  logic [63:0]    w [16];
  logic [1:0]     j;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;
  logic [3:0]     sel_c;
  logic [3:0]     sel_d;

`ifdef BLAKE_ROUND_STALL_EN
  assign hold_step = stall;
`else
  assign hold_step = 1'b0;
`endif

  // State, working state, step index and latency counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      v_out       <= '0;
      counter_idx <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_next;
      v_out       <= v_next;
      counter_idx <= idx_next;
      wait_cnt    <= wait_next;
    end
  end

  // Next-state decode; stall only freezes the in-flight states
  always_comb begin
    state_next = state;
    v_next     = v_out;
    idx_next   = counter_idx;
    wait_next  = wait_cnt;
    capture    = 1'b0;
    g_start    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          v_next     = v_init;
          idx_next   = '0;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!hold_step) begin
          g_start = 1'b1;
          if (G_LAT == 0) begin
            capture = 1'b1;
          end else begin
            wait_next  = WAIT_INIT;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!hold_step) begin
          if (wait_cnt == 3'd0) begin
            capture = 1'b1;
          end else begin
            wait_next = wait_cnt - 3'd1;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // The last step parks the index at its final value so it never wraps
    if (capture) begin
      v_next = v_state_next;
      if (counter_idx == LAST_IDX) begin
        state_next = S_DONE;
      end else begin
        idx_next   = counter_idx + 7'd1;
        state_next = S_ISSUE;
      end
    end
  end

  // Column steps take one word from each row at the same column;
  // diagonal steps rotate rows 1..3 by 1..3 columns
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w[k] = v_out[1023 - 64*k -: 64];
    end
    j     = counter_idx[1:0];
    sel_a = {2'b00, j};
    if (!counter_idx[2]) begin
      sel_b = {2'b01, j};
      sel_c = {2'b10, j};
      sel_d = {2'b11, j};
    end else begin
      sel_b = {2'b01, j + 2'd1};
      sel_c = {2'b10, j + 2'd2};
      sel_d = {2'b11, j + 2'd3};
    end
    a_in = w[sel_a];
    b_in = w[sel_b];
    c_in = w[sel_c];
    d_in = w[sel_d];
  end

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Bench for blake_round_ctrl: three instances (G_LAT 0, 1, 3) share start and
// v_init; each is closed through a behavioural G core + state merge. A
// reference compression computes the state before every step; the G_LAT=1
// instance is checked against it on every cycle of a run.
module tb_blake_round_ctrl;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          start  = 1'b0;
  logic          ident  = 1'b1;
  logic [1023:0] v_init = '0;
`ifdef BLAKE_ROUND_STALL_EN
  logic          stall1 = 1'b0;
`endif

  logic [1023:0] vsn0, vsn1, vsn3, v0, v1, v3;
  logic [6:0]    idx0, idx1, idx3;
  logic [63:0]   a0, b0, c0, d0, a1, b1, c1, d1, a3, b3, c3, d3;
  logic          gs0, gs1, gs3, busy0, busy1, busy3, done0, done1, done3;

  int errors = 0;
  int checks = 0;

  logic [1023:0] snap [0:128];

  int qa [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int qb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  int qc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  int qd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

  int sigma [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  logic [63:0] cst [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  logic [63:0] iv [8] = '{
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
  };

  // Padded one-block message 8'h00 (bit length 8)
  logic [63:0] msg [16] = '{
    64'h0080000000000000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0000000000000001, 64'h0, 64'h0000000000000008
  };

  int          lit_k   [3]    = '{0, 5, 7};
  logic [63:0] lit_ops [3][4] = '{'{64'h00, 64'h04, 64'h08, 64'h0C},
                                  '{64'h01, 64'h06, 64'h0B, 64'h0C},
                                  '{64'h03, 64'h04, 64'h09, 64'h0E}};

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] word(input logic [1023:0] v, input int k);
    return v[1023 - 64*k -: 64];
  endfunction

  function automatic logic [1023:0] put(input logic [1023:0] v, input int k, input logic [63:0] x);
    logic [1023:0] r;
    r = v;
    r[1023 - 64*k -: 64] = x;
    return r;
  endfunction

  function automatic logic [255:0] g_core(input logic [63:0] ai, bi, ci, di, input int r, input int s);
    logic [63:0] a, b, c, d;
    int e0, e1;
    a = ai; b = bi; c = ci; d = di;
    e0 = sigma[r % 10][2*s];
    e1 = sigma[r % 10][2*s + 1];
    a = a + b + (msg[e0] ^ cst[e1]);
    d = rotr(d ^ a, 32);
    c = c + d;
    b = rotr(b ^ c, 25);
    a = a + b + (msg[e1] ^ cst[e0]);
    d = rotr(d ^ a, 16);
    c = c + d;
    b = rotr(b ^ c, 11);
    return {a, b, c, d};
  endfunction

  // G core + state merge seen by a DUT: results go back to the step's slots
  function automatic logic [1023:0] merge(input logic [1023:0] v, input logic [6:0] idx,
                                          input logic [63:0] a, b, c, d, input logic idm);
    logic [255:0] g;
    logic [1023:0] r;
    int s;
    if (idm) return v;
    s = int'(idx[2:0]);
    g = g_core(a, b, c, d, int'(idx[6:3]), s);
    r = put(v, qa[s], g[255:192]);
    r = put(r, qb[s], g[191:128]);
    r = put(r, qc[s], g[127:64]);
    r = put(r, qd[s], g[63:0]);
    return r;
  endfunction

  always_comb vsn0 = merge(v0, idx0, a0, b0, c0, d0, ident);
  always_comb vsn1 = merge(v1, idx1, a1, b1, c1, d1, ident);
  always_comb vsn3 = merge(v3, idx3, a3, b3, c3, d3, ident);

  blake_round_ctrl #(.NUM_ROUNDS(16), .G_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start),
`ifdef BLAKE_ROUND_STALL_EN
    .stall(1'b0),
`endif
    .v_init(v_init), .v_state_next(vsn0), .v_out(v0), .counter_idx(idx0),
    .a_in(a0), .b_in(b0), .c_in(c0), .d_in(d0),
    .g_start(gs0), .busy(busy0), .done(done0));

  blake_round_ctrl #(.NUM_ROUNDS(16), .G_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef BLAKE_ROUND_STALL_EN
    .stall(stall1),
`endif
    .v_init(v_init), .v_state_next(vsn1), .v_out(v1), .counter_idx(idx1),
    .a_in(a1), .b_in(b1), .c_in(c1), .d_in(d1),
    .g_start(gs1), .busy(busy1), .done(done1));

  blake_round_ctrl #(.NUM_ROUNDS(16), .G_LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start),
`ifdef BLAKE_ROUND_STALL_EN
    .stall(1'b0),
`endif
    .v_init(v_init), .v_state_next(vsn3), .v_out(v3), .counter_idx(idx3),
    .a_in(a3), .b_in(b3), .c_in(c3), .d_in(d3),
    .g_start(gs3), .busy(busy3), .done(done3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int k = 15; k >= 0; k--) if (word(act, k) !== word(exp, k)) bad = k;
      $display("FAIL %s: word %0d got %h expected %h", nm, bad, word(act, bad), word(exp, bad));
    end
  endtask

  // Reference compression: state before every step, straight from the rules
  task automatic build_snap();
    logic [63:0] w [16];
    logic [255:0] g;
    logic [1023:0] p;
    int s;
    for (int k = 0; k < 16; k++) w[k] = word(v_init, k);
    snap[0] = v_init;
    for (int k = 0; k < 128; k++) begin
      s = k % 8;
      if (!ident) begin
        g = g_core(w[qa[s]], w[qb[s]], w[qc[s]], w[qd[s]], k / 8, s);
        w[qa[s]] = g[255:192];
        w[qb[s]] = g[191:128];
        w[qc[s]] = g[127:64];
        w[qd[s]] = g[63:0];
      end
      p = '0;
      for (int i = 0; i < 16; i++) p = put(p, i, w[i]);
      snap[k + 1] = p;
    end
  endtask

  task automatic run(input bit hold, input int abort_t, input int stall_t, input bit lits);
    int stall_len, last, te, k, s;
    int t_done0, t_done1, t_done3, n0, n1, n3, ngs;
    string tag;
    stall_len = (stall_t >= 0) ? 10 : 0;
    last = hold ? 258 : 514 + stall_len;
    t_done0 = -1; t_done1 = -1; t_done3 = -1;
    n0 = 0; n1 = 0; n3 = 0; ngs = 0;
    build_snap();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
`ifdef BLAKE_ROUND_STALL_EN
      if (stall_t >= 0) stall1 = (t >= stall_t && t < stall_t + stall_len);
`endif
      if (stall_len == 0 || t <= stall_t) te = t;
      else if (t <= stall_t + stall_len) te = stall_t;
      else te = t - stall_len;
      tag = $sformatf("t=%0d", t);
      if (done0) begin n0++; t_done0 = t; end
      if (done1) begin n1++; t_done1 = t; end
      if (done3) begin n3++; t_done3 = t; end
      if (gs1) ngs++;
      if (te < 256) begin
        k = te / 2;
        s = k % 8;
        chk({"g_start ", tag}, 64'(gs1), 64'(te % 2 == 0));
        chk({"counter_idx ", tag}, 64'(idx1), 64'(k));
        chk({"busy ", tag}, 64'(busy1), 64'd1);
        chk({"done ", tag}, 64'(done1), 64'd0);
        chkv({"v_out ", tag}, v1, snap[k]);
        chk({"a_in ", tag}, a1, word(snap[k], qa[s]));
        chk({"b_in ", tag}, b1, word(snap[k], qb[s]));
        chk({"c_in ", tag}, c1, word(snap[k], qc[s]));
        chk({"d_in ", tag}, d1, word(snap[k], qd[s]));
        if (lits && te % 2 == 0) begin
          for (int i = 0; i < 3; i++) begin
            if (k == lit_k[i]) begin
              chk($sformatf("lit a step %0d", k), a1, lit_ops[i][0]);
              chk($sformatf("lit b step %0d", k), b1, lit_ops[i][1]);
              chk($sformatf("lit c step %0d", k), c1, lit_ops[i][2]);
              chk($sformatf("lit d step %0d", k), d1, lit_ops[i][3]);
            end
          end
        end
      end else if (te == 256) begin
        chk({"done pulse ", tag}, 64'(done1), 64'd1);
        chk({"busy at done ", tag}, 64'(busy1), 64'd1);
        chk({"g_start at done ", tag}, 64'(gs1), 64'd0);
        chk({"counter_idx at done ", tag}, 64'(idx1), 64'd127);
        chkv({"v_out at done ", tag}, v1, snap[128]);
      end else if (te == 257) begin
        chk({"busy after done ", tag}, 64'(busy1), 64'd0);
        chk({"done after done ", tag}, 64'(done1), 64'd0);
        chk({"g_start idle ", tag}, 64'(gs1), 64'd0);
        chkv({"v_out hold ", tag}, v1, snap[128]);
      end else if (te == 258 && hold) begin
        chk({"restart busy ", tag}, 64'(busy1), 64'd1);
        chk({"restart g_start ", tag}, 64'(gs1), 64'd1);
        chk({"restart counter_idx ", tag}, 64'(idx1), 64'd0);
        chkv({"restart v_out ", tag}, v1, snap[0]);
      end
      if (t == abort_t) begin
        #2 rst = 1'b1;
        #1;
        chkv("reset v_out", v1, '0);
        chk("reset counter_idx", 64'(idx1), 64'd0);
        chk("reset busy", 64'(busy1), 64'd0);
        chk("reset g_start", 64'(gs1), 64'd0);
        repeat (3) begin
          @(negedge clk);
          chk("no done in reset u0", 64'(done0), 64'd0);
          chk("no done in reset u1", 64'(done1), 64'd0);
          chk("no done in reset u3", 64'(done3), 64'd0);
        end
        rst = 1'b0;
        return;
      end
    end
    if (!hold) begin
      chk("done time G_LAT=1", 64'(t_done1), 64'(256 + stall_len));
      chk("done count G_LAT=1", 64'(n1), 64'd1);
      chk("g_start count", 64'(ngs), 64'd128);
      chk("done time G_LAT=0", 64'(t_done0), 64'd128);
      chk("done count G_LAT=0", 64'(n0), 64'd1);
      chk("done time G_LAT=3", 64'(t_done3), 64'd512);
      chk("done count G_LAT=3", 64'(n3), 64'd1);
      chkv("final v G_LAT=0", v0, snap[128]);
      chkv("final v G_LAT=1", v1, snap[128]);
      chkv("final v G_LAT=3", v3, snap[128]);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chkv("por v_out", v1, '0);
    chk("por counter_idx", 64'(idx1), 64'd0);
    chk("por busy", 64'(busy1), 64'd0);
    chk("por done", 64'(done1), 64'd0);
    chk("por g_start", 64'(gs1), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Operand mapping with an identity G core
    ident = 1'b1;
    for (int k = 0; k < 16; k++) v_init = put(v_init, k, 64'(k));
    run(1'b0, -1, -1, 1'b1);

    // Full BLAKE-512 compression of the one-byte message
    ident = 1'b0;
    for (int k = 0; k < 8; k++) v_init = put(v_init, k, iv[k]);
    for (int k = 8; k < 16; k++) v_init = put(v_init, k, cst[k - 8]);
    v_init = put(v_init, 12, cst[4] ^ 64'd8);
    v_init = put(v_init, 13, cst[5] ^ 64'd8);
    run(1'b0, -1, -1, 1'b0);

    // Abort at step 40, then a clean restart
    run(1'b0, 80, -1, 1'b0);
    run(1'b0, -1, -1, 1'b0);

    // start held high for the whole run
    run(1'b1, -1, -1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

`ifdef BLAKE_ROUND_STALL_EN
    // Ten stalled cycles during the WAIT of step 20
    run(1'b0, -1, 41, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
